convolution_processor: RTL and testbench

- Computes the full 1-D discrete convolution Z = X * Y.
- X is a fixed internal kernel. Y is read from an external synchronous-read memory (memY). Z is written to an external memory (memZ).
- Sits between a single-port-read Y RAM and a write-only Z RAM. Controlled by a start/busy/done handshake.

---
 rtl/convolution_processor.sv | 187 ++++++++++++++++++
 tb/tb_convolution_processor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/convolution_processor.sv
// rtl/convolution_processor.sv - full 1-D convolution of a fixed kernel with a Y RAM stream into a Z RAM
module convolution_processor #(
    parameter int DATA_WIDTH_MEMY_ADDR = 5,
    parameter int DATA_WIDTH_DATAY     = 8,
    parameter int DATA_WIDTH_SIZEY     = 5,
    parameter int DATA_WIDTH_DATAZ     = 16,
    parameter int DATA_WIDTH_MEMZ_ADDR = 6,
    parameter int SIZEX                = 5,
    parameter logic [SIZEX*DATA_WIDTH_DATAY-1:0] KERNEL_X =
        {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [DATA_WIDTH_DATAY-1:0]     dataY,
    input  logic [DATA_WIDTH_SIZEY-1:0]     sizeY,
    output logic [DATA_WIDTH_MEMY_ADDR-1:0] memY_addr,
    output logic [DATA_WIDTH_MEMZ_ADDR-1:0] memZ_addr,
    output logic [DATA_WIDTH_DATAZ-1:0]     dataZ,
    output logic                            writeZ,
    output logic                            busy,
    output logic                            done
);

    // j counts kernel taps; i and the i-j difference get one spare bit so
    // the difference can go negative without aliasing into a valid index.
    localparam int JW = (SIZEX > 1) ? $clog2(SIZEX) : 1;
    localparam int IW = DATA_WIDTH_MEMZ_ADDR + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_MAC,
        S_NEXTJ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic                            start_d_q;
    logic [DATA_WIDTH_SIZEY-1:0]     sy_q, sy_d;
    logic [DATA_WIDTH_MEMZ_ADDR-1:0] i_q, i_d;
    logic [JW-1:0]                   j_q, j_d;
    logic [DATA_WIDTH_DATAZ-1:0]     acc_q, acc_d;
    logic [DATA_WIDTH_MEMY_ADDR-1:0] memY_addr_q, memY_addr_d;
    logic [DATA_WIDTH_MEMZ_ADDR-1:0] memZ_addr_q, memZ_addr_d;
    logic [DATA_WIDTH_DATAZ-1:0]     dataZ_q, dataZ_d;
    logic                            writeZ_q, writeZ_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [DATA_WIDTH_DATAY-1:0]     kx [SIZEX];
    logic [DATA_WIDTH_DATAY-1:0]     x_sel;
    logic [DATA_WIDTH_DATAZ-1:0]     prod;
    logic [IW-1:0]                   diff;
    logic                            idx_ok;
    logic [IW-1:0]                   n_last;
    logic                            trigger;

    // Unpack the kernel into an indexable array.
    for (genvar g = 0; g < SIZEX; g++) begin : g_kernel
        assign kx[g] = KERNEL_X[g*DATA_WIDTH_DATAY +: DATA_WIDTH_DATAY];
    end

    assign x_sel   = kx[j_q];
    assign prod    = DATA_WIDTH_DATAZ'(x_sel) * DATA_WIDTH_DATAZ'(dataY);
    assign diff    = IW'(i_q) - IW'(j_q);
    assign idx_ok  = !diff[IW-1] && (diff < IW'(sy_q));
    // Index of the final output, N-1 = SIZEX + sY - 2 (only used when sY >= 1).
    assign n_last  = IW'(SIZEX) + IW'(sy_q) - IW'(2);
    assign trigger = start && !start_d_q && (state_q == S_IDLE);

    // State, counters and registered outputs; reset aborts at once.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= S_IDLE;
            start_d_q   <= 1'b0;
            sy_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            memY_addr_q <= '0;
            memZ_addr_q <= '0;
            dataZ_q     <= '0;
            writeZ_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_d_q   <= start;
            sy_q        <= sy_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            memY_addr_q <= memY_addr_d;
            memZ_addr_q <= memZ_addr_d;
            dataZ_q     <= dataZ_d;
            writeZ_q    <= writeZ_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: one tap per ADDR/WAIT/MAC/NEXTJ pass, one write per output.
    always_comb begin
        state_d     = state_q;
        sy_d        = sy_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        memY_addr_d = memY_addr_q;
        memZ_addr_d = memZ_addr_q;
        dataZ_d     = dataZ_q;
        writeZ_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    sy_d    = sizeY;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (sy_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (idx_ok) begin
                    memY_addr_d = diff[DATA_WIDTH_MEMY_ADDR-1:0];
                    state_d     = S_WAIT;
                end else begin
                    state_d = S_NEXTJ;
                end
            end
            S_WAIT: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d   = acc_q + prod;
                state_d = S_NEXTJ;
            end
            S_NEXTJ: begin
                if (j_q == JW'(SIZEX - 1)) begin
                    memZ_addr_d = i_q;
                    dataZ_d     = acc_q;
                    writeZ_d    = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    j_d     = j_q + JW'(1);
                    state_d = S_ADDR;
                end
            end
            S_WRITE: begin
                acc_d = '0;
                j_d   = '0;
                if (IW'(i_q) == n_last) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + DATA_WIDTH_MEMZ_ADDR'(1);
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign memY_addr = memY_addr_q;
    assign memZ_addr = memZ_addr_q;
    assign dataZ     = dataZ_q;
    assign writeZ    = writeZ_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_convolution_processor.sv
// tb/tb_convolution_processor.sv - scoreboard bench for convolution_processor
module tb_convolution_processor;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  dataY;
    logic [4:0]  sizeY;
    logic [4:0]  memY_addr;
    logic [5:0]  memZ_addr;
    logic [15:0] dataZ;
    logic        writeZ;
    logic        busy;
    logic        done;

    logic [7:0]  ymem [32];
    logic [21:0] sb [$];
    int          n_cmp;
    int          n_err;
    int          n_writes;

    convolution_processor dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .dataY     (dataY),
        .sizeY     (sizeY),
        .memY_addr (memY_addr),
        .memZ_addr (memZ_addr),
        .dataZ     (dataZ),
        .writeZ    (writeZ),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read Y RAM, one cycle of latency.
    always @(posedge clk) dataY <= ymem[memY_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference convolution with kernel {1,2,3,4,5}; pushes {addr,data}.
    task automatic push_expected(input int sy);
        int kern [5];
        int n;
        logic [15:0] acc;
        kern = '{1, 2, 3, 4, 5};
        n = (sy == 0) ? 0 : 5 + sy - 1;
        for (int i = 0; i < n; i++) begin
            acc = '0;
            for (int j = 0; j < 5; j++) begin
                if (i - j >= 0 && i - j < sy)
                    acc = acc + 16'(kern[j] * int'(ymem[i-j]));
            end
            sb.push_back({6'(i), acc});
        end
    endtask

    // Fresh rising edge on start.
    task automatic kick();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
    endtask

    // Drain the scoreboard until done, or until the cycle budget runs out.
    task automatic wait_done(input string tag, input int stop_after);
        int seen;
        logic [21:0] e;
        seen = 0;
        n_writes = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (writeZ) begin
                n_writes++;
                chk({tag, " busy during write"}, 32'(busy), 32'd1);
                if (sb.size() == 0) begin
                    chk({tag, " unexpected write"}, 32'(memZ_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk({tag, " addr"}, 32'(memZ_addr), 32'(e[21:16]));
                    chk({tag, " data"}, 32'(dataZ), 32'(e[15:0]));
                end
                if (stop_after != 0 && n_writes == stop_after) return;
            end
            if (done) begin
                seen = 1;
                chk({tag, " busy at done"}, 32'(busy), 32'd0);
                break;
            end
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " scoreboard empty"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    // With start held high, nothing more may happen.
    task automatic check_quiet(input string tag, input int cycles);
        int act;
        act = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (writeZ || busy || done) act++;
        end
        chk({tag, " quiet"}, 32'(act), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b1;
        start = 1'b0;
        sizeY = '0;
        for (int k = 0; k < 32; k++) ymem[k] = '0;
        repeat (3) @(negedge clk);
        chk("reset writeZ", 32'(writeZ), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset memZ_addr", 32'(memZ_addr), 32'd0);
        chk("reset dataZ", 32'(dataZ), 32'd0);
        chk("reset memY_addr", 32'(memY_addr), 32'd0);
        rstn = 1'b0;

        // Y = ones, start held high: one run only.
        for (int k = 0; k < 5; k++) ymem[k] = 8'd1;
        sizeY = 5'd5;
        push_expected(5);
        kick();
        @(negedge clk);
        chk("t1 busy after trigger", 32'(busy), 32'd1);
        wait_done("t1", 0);
        chk("t1 write count", 32'(n_writes), 32'd9);
        check_quiet("t1 held start", 40);

        // Single sample; sizeY and start change mid-run.
        ymem[0] = 8'd2;
        sizeY = 5'd1;
        push_expected(1);
        kick();
        @(negedge clk);
        sizeY = 5'd17;
        start = 1'b0;
        wait_done("t2", 0);
        chk("t2 write count", 32'(n_writes), 32'd5);

        // Longest Y, all 255.
        for (int k = 0; k < 32; k++) ymem[k] = 8'd255;
        sizeY = 5'd31;
        push_expected(31);
        kick();
        wait_done("t3", 0);
        chk("t3 write count", 32'(n_writes), 32'd35);
        chk("t3 last addr", 32'(memZ_addr), 32'd34);
        chk("t3 last data", 32'(dataZ), 32'd1275);

        // Empty Y: no writes, just done.
        sizeY = 5'd0;
        kick();
        wait_done("t4", 0);
        chk("t4 write count", 32'(n_writes), 32'd0);
        chk("t4 busy after", 32'(busy), 32'd0);

        // Reset mid-run after the third write.
        for (int k = 0; k < 5; k++) ymem[k] = 8'd1;
        sizeY = 5'd5;
        push_expected(5);
        kick();
        wait_done("t5", 3);
        #1 rstn = 1'b1;
        #1;
        chk("t5 writeZ async", 32'(writeZ), 32'd0);
        chk("t5 busy async", 32'(busy), 32'd0);
        chk("t5 done async", 32'(done), 32'd0);
        chk("t5 writes before reset", 32'(n_writes), 32'd3);
        check_quiet("t5 in reset", 10);
        sb.delete();
        @(negedge clk);
        rstn = 1'b0;
        push_expected(5);
        kick();
        wait_done("t5 rerun", 0);
        chk("t5 rerun count", 32'(n_writes), 32'd9);

        // Ramp Y; a mid-run start re-edge is ignored.
        for (int k = 0; k < 5; k++) ymem[k] = 8'(k + 1);
        push_expected(5);
        kick();
        repeat (4) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_done("t6", 0);
        chk("t6 write count", 32'(n_writes), 32'd9);
        check_quiet("t6 no rerun", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
